// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control. It produces the execute- and
// decode-stage forwarding selects, the load-use and branch stalls, and it
// runs the control side of the multi-cycle multiply. While the multiply is
// running, the pipeline is frozen and a bubble is sent to MEM on every
// frozen cycle.
module hazard_unit #(
    parameter int MULT_TIMEOUT = 48,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemToRegE,
    input  logic       MemToRegM,
    input  logic       BranchD,
    input  logic       MultStartE,
    input  logic       MultComplete,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MultBusy,
    output logic       MultError
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic   [CNT_W-1:0] busy_count;
    logic               lwstall;
    logic               branchstall;
    logic               multstall;

    // Execute-stage forwarding; M has priority over W, and register 0 is never forwarded
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE)) begin
            forwardAE = 2'b10;
        end else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) begin
            forwardAE = 2'b01;
        end
        if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE)) begin
            forwardBE = 2'b10;
        end else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) begin
            forwardBE = 2'b01;
        end
    end

    // Decode-stage branch-compare forwarding from ALUOutM
    always_comb begin
        forwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
        forwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
    end

    // Load-use, branch-operand and multiply-freeze hazard detection
    always_comb begin
        lwstall     = MemToRegE && ((RtE == RsD) || (RtE == RtD));
        branchstall = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemToRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
        // The start is seen in IDLE before the registered state catches up,
        // so the freeze begins in the same cycle as MultStartE.
        multstall   = ((state == IDLE) && MultStartE) || (state == MULT_BUSY);
    end

    // Stall and flush outputs; a multiply freeze overrides flushing E
    always_comb begin
        StallF   = lwstall | branchstall | multstall;
        StallD   = lwstall | branchstall | multstall;
        StallE   = multstall;
        FlushE   = (lwstall | branchstall) & ~multstall;
        FlushM   = multstall;
        MultBusy = multstall;
    end

    // Multiply handshake next-state logic; MultComplete outside MULT_BUSY is ignored
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (MultStartE)   state_next = MULT_BUSY;
            MULT_BUSY: if (MultComplete) state_next = MULT_DONE;
            MULT_DONE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register, saturating busy counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy_count <= '0;
            MultError  <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && MultStartE) begin
                busy_count <= '0;
            end else if ((state == MULT_BUSY) && !MultComplete) begin
                if (busy_count != '1) begin
                    busy_count <= busy_count + 1'b1;
                end
                // The flag rises on the same edge the counter reaches MULT_TIMEOUT.
                if (busy_count == CNT_W'(MULT_TIMEOUT - 1)) begin
                    MultError <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven vectors for the combinational hazard logic
// plus hand-written multiply, timeout and reset sequences, checked through
// an expected-value queue.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic       BranchD, MultStartE, MultComplete;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, StallF, StallD, StallE, FlushE, FlushM;
    logic       MultBusy, MultError;
    logic [12:0] actual;

    // Output bundle layout: {fAE[1:0], fBE[1:0], fAD, fBD, StallF, StallD, StallE, FlushE, FlushM, MultBusy, MultError}
    localparam logic [12:0] ZERO = 13'b00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] LU   = 13'b00_00_0_0_1_1_0_1_0_0_0;
    localparam logic [12:0] MS   = 13'b00_00_0_0_1_1_1_0_1_1_0;
    localparam logic [12:0] MSE  = 13'b00_00_0_0_1_1_1_0_1_1_1;
    localparam logic [12:0] ERR  = 13'b00_00_0_0_0_0_0_0_0_0_1;

    typedef struct {
        string      name;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, start, done;
        logic [12:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
        .MultStartE(MultStartE), .MultComplete(MultComplete),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushE(FlushE), .FlushM(FlushM),
        .MultBusy(MultBusy), .MultError(MultError)
    );

    assign actual = {forwardAE, forwardBE, forwardAD, forwardBD, StallF, StallD,
                     StallE, FlushE, FlushM, MultBusy, MultError};

    always #5 clk = ~clk;

    function automatic vec_t zv(input string n, input logic [12:0] e);
        vec_t v;
        v.name = n;
        v.rs_d = '0; v.rt_d = '0; v.rs_e = '0; v.rt_e = '0;
        v.wr_e = '0; v.wr_m = '0; v.wr_w = '0;
        v.rw_e = 0; v.rw_m = 0; v.rw_w = 0; v.m2r_e = 0; v.m2r_m = 0;
        v.br_d = 0; v.start = 0; v.done = 0;
        v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RsD = v.rs_d; RtD = v.rt_d; RsE = v.rs_e; RtE = v.rt_e;
        WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
        RegWriteE = v.rw_e; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
        MemToRegE = v.m2r_e; MemToRegM = v.m2r_m; BranchD = v.br_d;
        MultStartE = v.start; MultComplete = v.done;
    endtask

    task automatic apply_stimulus(input vec_t v);
        sb_t s;
        drive(v);
        s.name = v.name;
        s.exp  = v.exp;
        sb_q.push_back(s);
    endtask

    task automatic check_output();
        sb_t s;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got %b required an expected entry", actual);
        end else begin
            s = sb_q.pop_front();
            if (actual !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b required %b", s.name, actual, s.exp);
            end
        end
    endtask

    // One checked cycle: drive after the edge, compare at the falling edge.
    task automatic step(input vec_t v);
        apply_stimulus(v);
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // Combinational vectors, all taken with the FSM idle
        v = zv("reset_idle",      ZERO); tbl.push_back(v);
        v = zv("fwdA_m_priority", 13'b10_00_0_0_0_0_0_0_0_0_0);
        v.rs_e = 5; v.rw_m = 1; v.wr_m = 5; v.rw_w = 1; v.wr_w = 5; tbl.push_back(v);
        v = zv("fwdA_w",          13'b01_00_0_0_0_0_0_0_0_0_0);
        v.rs_e = 5; v.rw_m = 0; v.wr_m = 5; v.rw_w = 1; v.wr_w = 5; tbl.push_back(v);
        v = zv("fwdA_reg0",       ZERO);
        v.rs_e = 0; v.rw_m = 1; v.wr_m = 0; v.rw_w = 1; v.wr_w = 0; tbl.push_back(v);
        v = zv("fwdB_m",          13'b00_10_0_0_0_0_0_0_0_0_0);
        v.rt_e = 7; v.rw_m = 1; v.wr_m = 7; tbl.push_back(v);
        v = zv("fwdB_w",          13'b00_01_0_0_0_0_0_0_0_0_0);
        v.rt_e = 7; v.rw_m = 1; v.wr_m = 3; v.rw_w = 1; v.wr_w = 7; tbl.push_back(v);
        v = zv("fwdB_no_write",   ZERO);
        v.rt_e = 7; v.wr_m = 7; v.wr_w = 7; tbl.push_back(v);
        v = zv("load_use_rs",     LU);
        v.m2r_e = 1; v.rt_e = 8; v.rs_d = 8; tbl.push_back(v);
        v = zv("load_use_clear",  ZERO);
        v.m2r_e = 1; v.rt_e = 8; v.rs_d = 9; v.rt_d = 10; tbl.push_back(v);
        v = zv("load_use_rt",     LU);
        v.m2r_e = 1; v.rt_e = 10; v.rs_d = 9; v.rt_d = 10; tbl.push_back(v);
        v = zv("load_use_r0",     LU);
        v.m2r_e = 1; tbl.push_back(v);
        v = zv("branch_e_writer", LU);
        v.br_d = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; tbl.push_back(v);
        v = zv("branch_fwd_m",    13'b00_00_1_0_0_0_0_0_0_0_0);
        v.br_d = 1; v.rw_m = 1; v.wr_m = 4; v.rs_d = 4; tbl.push_back(v);
        v = zv("branch_load_m",   13'b00_00_0_1_1_1_0_1_0_0_0);
        v.br_d = 1; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 4; v.rt_d = 4; tbl.push_back(v);
        v = zv("no_branch",       ZERO);
        v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; tbl.push_back(v);
        v = zv("fwdBD",           13'b00_00_0_1_0_0_0_0_0_0_0);
        v.rt_d = 6; v.rw_m = 1; v.wr_m = 6; tbl.push_back(v);
        v = zv("fwdAD_reg0",      ZERO);
        v.rw_m = 1; tbl.push_back(v);

        rst = 1'b0;
        drive(zv("init", ZERO));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Multiply: start held, MultComplete in the 32nd frozen cycle
        for (int i = 1; i <= 32; i++) begin
            v = zv($sformatf("mult_busy_c%0d", i), MS);
            v.start = 1; v.done = (i == 32);
            step(v);
        end
        v = zv("mult_done", ZERO); v.start = 1; step(v);
        v = zv("mult_restart_idle", MS); v.start = 1; step(v);
        v = zv("mult_restart_busy", MS); v.start = 1; v.done = 1; step(v);
        v = zv("mult_restart_done", ZERO); step(v);
        v = zv("complete_ignored", ZERO); v.done = 1; step(v);
        v = zv("still_idle", ZERO); step(v);

        // Multiply start coinciding with a load-use hazard
        v = zv("mult_lw_first", MS);
        v.start = 1; v.m2r_e = 1; v.rt_e = 8; v.rs_d = 8; step(v);
        v.name = "mult_lw_busy"; v.done = 1; step(v);
        v = zv("mult_lw_done", LU);
        v.m2r_e = 1; v.rt_e = 8; v.rs_d = 8; step(v);
        v = zv("mult_lw_idle", ZERO); step(v);

        // Timeout: 48 busy cycles without completion raise the sticky flag
        v = zv("tmo_start", MS); v.start = 1; step(v);
        for (int b = 1; b <= 50; b++) begin
            v = zv($sformatf("tmo_busy_b%0d", b), (b <= 48) ? MS : MSE);
            v.start = 1;
            step(v);
        end
        v = zv("tmo_complete", MSE); v.start = 1; v.done = 1; step(v);
        v = zv("tmo_done_sticky", ERR); step(v);
        v = zv("tmo_restart", MSE); v.start = 1; step(v);
        v = zv("tmo_busy_again", MSE); v.start = 1; step(v);

        // Reset for one edge in the middle of a multiply
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        v = zv("after_reset", ZERO); step(v);
        v = zv("after_reset_idle", ZERO); step(v);
        v = zv("after_reset_start", MS); v.start = 1; step(v);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control counterpart to the execute stage: generates the forwarding selects and the stall/flush signals that the execute stage and the pipeline registers consume.
- Runs the multi-cycle multiply handshake from the control side. It sees MultStartE, freezes the pipeline while the multiplier borrows the ALU, and releases the pipeline on MultComplete.
- Also handles load-use and decode-stage branch hazards.
- Sits beside the datapath; no data path of its own.

Parameters:
- MULT_TIMEOUT, 48, number of cycles in MULT_BUSY without MultComplete before MultError is raised.
- CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > MULT_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- RsD, RtD  in  5  decode-stage source registers
- RsE, RtE  in  5  execute-stage source registers
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
- MemToRegE, MemToRegM  in  1  load in the E or M stage
- BranchD  in  1  branch compare in decode
- MultStartE  in  1  multiply (hi or lo product) in the execute stage
- MultComplete  in  1  multiplier result valid (from execute)
- forwardAE, forwardBE  out  2  10 = ALUOutM, 01 = ResultW, 00 = register file
- forwardAD, forwardBD  out  1  decode-stage branch forward from ALUOutM
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushE, FlushM  out  1  insert a bubble into ID/EX or EX/MEM
- MultBusy  out  1  multiplier in progress
- MultError  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. When rst==0 at a rising edge:
  - state = IDLE, counter = 0, MultError = 0.
  - All outputs read 0 in the cycle after reset. forward* = 00, all stalls and flushes = 0, MultBusy = 0.
  - Reset during MULT_BUSY aborts the multiply and returns to IDLE.
- Forwarding (combinational):
  - forwardAE = 10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE.
  - Otherwise forwardAE = 01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE.
  - Otherwise forwardAE = 00. The M stage has priority over W.
  - forwardBE uses the same rules with RtE.
  - forwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. forwardBD uses the same rule with RtD.
  - Register 0 is never forwarded.
- lwstall = MemToRegE && (RtE==RsD || RtE==RtD).
- branchstall is asserted when BranchD && (A or B):
  - A: RegWriteE && (WriteRegE==RsD || WriteRegE==RtD).
  - B: MemToRegM && (WriteRegM==RsD || WriteRegM==RtD).
- State machine, states IDLE / MULT_BUSY / MULT_DONE:
  - IDLE -> MULT_BUSY when MultStartE=1. Counter is cleared.
  - MULT_BUSY -> MULT_DONE when MultComplete=1.
  - Otherwise MULT_BUSY stays and the counter increments, saturating.
  - MULT_DONE -> IDLE unconditionally after 1 cycle.
  - MultComplete outside MULT_BUSY is ignored.
- multstall is combinational: (state==IDLE && MultStartE) || state==MULT_BUSY.
  - This stalls the pipeline on the first cycle, before the registered state catches up.
  - In MULT_DONE, multstall=0. The E-stage result is captured into M and the pipeline resumes.
  - Multiply latency seen by the pipeline = cycles until MultComplete + 1.
- MultBusy = multstall.
- Output equations:
  - StallF = StallD = lwstall | branchstall | multstall.
  - StallE = multstall. This holds MultStartE and the operands stable for the multiplier.
  - FlushE = (lwstall | branchstall) & ~multstall. A multiply freeze has priority: nothing is flushed behind a held E stage.
  - FlushM = multstall. A bubble goes to MEM each frozen cycle so no ALU byproduct is written.
- Back-to-back multiplies: a second MultStartE arriving in MULT_DONE is not a new start. The registered state returns to IDLE first, and the new start is detected in the next IDLE cycle.
- Timeout: when the counter reaches MULT_TIMEOUT in MULT_BUSY, MultError is set.
  - MultError stays set until reset.
  - The FSM keeps waiting; MultError does not release the pipeline.

Test Plan:
- Forward priority: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> forwardAE=10. Drop RegWriteM -> 01. Set WriteRegM=WriteRegW=0, RsE=0 -> 00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 in the same cycle, StallE=0. Change RsD=9, RtD=10 -> all 0.
- Multiply handshake: MultStartE=1 held, MultComplete pulses 1 cycle 32 cycles later.
  - StallF/D/E=1 and FlushM=1 for 32 cycles.
  - The next cycle (MULT_DONE) shows all stalls 0.
  - The FSM is back in IDLE one cycle after that.
- Simultaneous hazards: MultStartE=1 with lwstall=1 -> StallE=1, FlushE=0, StallF=1.
- Timeout and reset: MultStartE=1 with no MultComplete for 48 cycles -> MultError=1 at cycle 48, stalls remain. rst=0 for one edge -> all outputs 0 and state IDLE on the next cycle.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=4, RsD=4 -> StallD=1, FlushE=1. Next cycle with the writer in M (RegWriteM=1, WriteRegM=4) and MemToRegM=0 -> no stall, forwardAD=1.
